// File: rtl/result_uart_sender.sv
// Streams the N x N result RAM bank back to the host, one UART byte at a time,
// in C row-major order with each 32-bit word sent MSB byte first.
module result_uart_sender #(
  parameter int N      = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [6:0]              a_seg_cnt,
  input  logic [6:0]              w_seg_cnt,
  output logic [ADDR_W-1:0]       ram_c_addr,
  output logic [N*N-1:0]          ram_c_rden,
  input  logic [N*N*DATA_W-1:0]   ram_c_data,
  output logic [7:0]              uart_tx_data,
  output logic                    uart_send_data,
  input  logic                    uart_tx_done,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (N > 1) ? $clog2(N * N) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, LOAD, SEND, WAIT_TX, ADV, FIN
  } state_t;

  state_t state, state_nxt;

  logic [6:0]        a_cnt, w_cnt;
  logic [6:0]        a_idx, w_idx;
  logic [IW-1:0]     i_idx, j_idx;
  logic [1:0]        byte_idx;
  logic [DATA_W-1:0] word;
  logic [ADDR_W-1:0] addr_calc;
  logic [BW-1:0]     bank;
  logic              last_a, last_w, last_i, last_j, all_last;
  logic              zero_cnt;

  assign addr_calc = ADDR_W'(a_idx) * ADDR_W'(w_cnt) + ADDR_W'(w_idx);
  assign bank      = BW'(int'(i_idx) * N + int'(j_idx));

  assign last_j   = j_idx == IW'(N - 1);
  assign last_i   = i_idx == IW'(N - 1);
  assign last_w   = w_idx == w_cnt - 7'd1;
  assign last_a   = a_idx == a_cnt - 7'd1;
  assign all_last = last_j && last_w && last_i && last_a;
  assign zero_cnt = (a_seg_cnt == 7'd0) || (w_seg_cnt == 7'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = zero_cnt ? FIN : RD_REQ;
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    state_nxt = WAIT_TX;
      WAIT_TX: if (uart_tx_done)
                 state_nxt = (byte_idx == 2'd3) ? ADV : SEND;
      ADV:     state_nxt = all_last ? FIN : RD_REQ;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_c_addr     = '0;
    ram_c_rden     = '0;
    uart_tx_data   = '0;
    uart_send_data = 1'b0;
    if (state == RD_REQ || state == RD_WAIT) begin
      ram_c_addr = addr_calc;
      ram_c_rden = (N * N)'(1) << bank;
    end
    if (state == SEND || state == WAIT_TX)
      uart_tx_data = word[DATA_W-1 -: 8];
    uart_send_data = state == SEND;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt    <= '0;
      w_cnt    <= '0;
      a_idx    <= '0;
      w_idx    <= '0;
      i_idx    <= '0;
      j_idx    <= '0;
      byte_idx <= '0;
      word     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          a_cnt <= a_seg_cnt;
          w_cnt <= w_seg_cnt;
          a_idx <= '0;
          w_idx <= '0;
          i_idx <= '0;
          j_idx <= '0;
          busy  <= 1'b1;
        end
        RD_WAIT: word <= ram_c_data[int'(bank)*DATA_W +: DATA_W];
        LOAD:    byte_idx <= '0;
        WAIT_TX: if (uart_tx_done) begin
          word     <= {word[DATA_W-9:0], 8'h00};
          byte_idx <= byte_idx + 2'd1;
        end
        // Odometer: j fastest, then w, then i, then a.
        ADV: begin
          if (!last_j) j_idx <= j_idx + IW'(1);
          else begin
            j_idx <= '0;
            if (!last_w) w_idx <= w_idx + 7'd1;
            else begin
              w_idx <= '0;
              if (!last_i) i_idx <= i_idx + IW'(1);
              else begin
                i_idx <= '0;
                a_idx <= last_a ? 7'd0 : a_idx + 7'd1;
              end
            end
          end
        end
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_sender.sv
// Directed bench for result_uart_sender: RAM and UART responders plus a
// row-major reference model checked every cycle.
module tb_result_uart_sender;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst, start, uart_tx_done;
  logic [6:0] a_seg_cnt, w_seg_cnt;
  logic [7:0] ram_c_addr;
  logic [N*N-1:0] ram_c_rden;
  logic [N*N*32-1:0] ram_c_data;
  logic [7:0] uart_tx_data;
  logic uart_send_data, busy, done;

  always #5 clk = ~clk;

  result_uart_sender #(.N(N), .ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_seg_cnt(a_seg_cnt), .w_seg_cnt(w_seg_cnt),
    .ram_c_addr(ram_c_addr), .ram_c_rden(ram_c_rden),
    .ram_c_data(ram_c_data), .uart_tx_data(uart_tx_data),
    .uart_send_data(uart_send_data), .uart_tx_done(uart_tx_done),
    .busy(busy), .done(done)
  );

  int tests = 0, failed = 0;
  int done_cnt = 0, sent = 0, spur_cnt = 0;
  int dly_min = 10, dly_max = 10;
  bit spur_en = 1'b0;
  logic [7:0] exp_q[$];
  int rd_addr_q[$];
  int rd_bank_q[$];
  logic [31:0] mem [N*N][256];
  logic [7:0] lit16 [16] = '{
    8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00,
    8'h40, 8'h40, 8'h00, 8'h00, 8'h40, 8'h80, 8'h00, 8'h00};

  function automatic void check(input bit ok, input string name,
                                input logic [31:0] act,
                                input logic [31:0] req);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Bank RAM: data is valid only in the cycle after the first rden cycle.
  logic [31:0] dout [N*N];
  logic [N*N-1:0] rden_q = '0;
  always @(posedge clk) begin
    for (int k = 0; k < N*N; k++)
      dout[k] <= (ram_c_rden[k] && !rden_q[k]) ?
                 mem[k][ram_c_addr] : (32'hDEAD0000 | k);
    rden_q <= ram_c_rden;
  end
  assign ram_c_data = {dout[3], dout[2], dout[1], dout[0]};

  // UART responder, with optional spurious tx_done in the second rden cycle.
  initial begin
    int cd;
    logic [N*N-1:0] prv;
    cd = 0;
    prv = '0;
    uart_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      uart_tx_done = 1'b0;
      if (rst) cd = 0;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) uart_tx_done = 1'b1;
      end else if (uart_send_data)
        cd = int'($urandom_range(dly_max, dly_min));
      else if (spur_en && ram_c_rden != 0 && prv != 0) begin
        uart_tx_done = 1'b1;
        spur_cnt++;
      end
      prv = ram_c_rden;
    end
  end

  // Compare process against the reference queues.
  initial begin
    bit prev_send, pending;
    logic [7:0] held, eb;
    logic [N*N-1:0] prev_rden;
    logic [7:0] prev_addr;
    int run, ea, ebk;
    prev_send = 0; pending = 0; run = 0;
    prev_rden = '0; prev_addr = '0; held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_send = 0; pending = 0; run = 0; prev_rden = '0;
        continue;
      end
      if (done) done_cnt++;
      if (uart_send_data) begin
        check(!prev_send, "send_gap", 32'(prev_send), 0);
        check(busy, "busy_in_send", 32'(busy), 1);
        if (exp_q.size() == 0)
          check(0, "unexpected_send", 32'(uart_tx_data), 0);
        else begin
          eb = exp_q.pop_front();
          check(uart_tx_data == eb, "tx_byte", 32'(uart_tx_data), 32'(eb));
        end
        sent++;
        pending = 1;
        held = uart_tx_data;
      end else if (pending) begin
        if (uart_tx_done) pending = 0;
        else check(uart_tx_data == held, "tx_stable",
                   32'(uart_tx_data), 32'(held));
      end
      prev_send = uart_send_data;
      check($countones(ram_c_rden) <= 1, "rden_onehot", 32'(ram_c_rden), 0);
      if (ram_c_rden != 0) begin
        if (run == 0) begin
          if (rd_addr_q.size() == 0)
            check(0, "unexpected_read", 32'(ram_c_rden), 0);
          else begin
            ea = rd_addr_q.pop_front();
            ebk = rd_bank_q.pop_front();
            check(ram_c_rden == (N*N)'(1 << ebk), "rden_bank",
                  32'(ram_c_rden), 32'(1 << ebk));
            check(ram_c_addr == 8'(ea), "rd_addr", 32'(ram_c_addr), 32'(ea));
          end
        end else begin
          check(ram_c_rden == prev_rden, "rden_hold",
                32'(ram_c_rden), 32'(prev_rden));
          check(ram_c_addr == prev_addr, "addr_hold",
                32'(ram_c_addr), 32'(prev_addr));
        end
        run++;
      end else if (run > 0) begin
        check(run == 2, "rden_len", 32'(run), 2);
        run = 0;
      end
      prev_rden = ram_c_rden;
      prev_addr = ram_c_addr;
    end
  end

  task automatic expect_run(input int ac, input int wc);
    logic [31:0] wd;
    for (int a = 0; a < ac; a++)
      for (int i = 0; i < N; i++)
        for (int w = 0; w < wc; w++)
          for (int j = 0; j < N; j++) begin
            int adr;
            adr = (a * wc + w) % 256;
            wd = mem[i*N+j][adr];
            rd_addr_q.push_back(adr);
            rd_bank_q.push_back(i * N + j);
            for (int b = 3; b >= 0; b--) exp_q.push_back(wd[b*8 +: 8]);
          end
  endtask

  task automatic pulse_start(input logic [6:0] ac, input logic [6:0] wc);
    @(negedge clk);
    a_seg_cnt = ac;
    w_seg_cnt = wc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_seg_cnt = 7'h55;
    w_seg_cnt = 7'h2A;
  endtask

  task automatic wait_done(input int target, input int limit);
    int c;
    c = 0;
    while (done_cnt < target && c < limit) begin
      @(negedge clk);
      c++;
    end
    check(done_cnt >= target, "done_timeout", 32'(done_cnt), 32'(target));
    repeat (5) @(negedge clk);
    check(done_cnt == target, "done_count", 32'(done_cnt), 32'(target));
    check(exp_q.size() == 0, "bytes_left", 32'(exp_q.size()), 0);
    check(rd_addr_q.size() == 0, "reads_left", 32'(rd_addr_q.size()), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({ram_c_addr, ram_c_rden, uart_tx_data} == '0, name,
          32'({ram_c_addr, ram_c_rden, uart_tx_data}), 0);
    check({uart_send_data, busy, done} == 3'b000, name,
          32'({uart_send_data, busy, done}), 0);
  endtask

  initial begin
    int base, c;
    rst = 1'b1; start = 1'b0;
    a_seg_cnt = '0; w_seg_cnt = '0;
    for (int k = 0; k < N*N; k++)
      for (int a = 0; a < 256; a++) mem[k][a] = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_outputs");
    rst = 1'b0;

    // 2x2 result matrix
    mem[0][0] = 32'h3F800000; mem[1][0] = 32'h40000000;
    mem[2][0] = 32'h40400000; mem[3][0] = 32'h40800000;
    expect_run(1, 1);
    check(exp_q.size() == 16, "model_len16", 32'(exp_q.size()), 16);
    for (int k = 0; k < 16; k++)
      check(exp_q[k] == lit16[k], "model_2x2", 32'(exp_q[k]), 32'(lit16[k]));
    pulse_start(7'd1, 7'd1);
    wait_done(1, 2000);

    // Row-major ordering, a=2 w=3
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < 256; k++)
          mem[i*N+j][k] = {4'(i), 4'(j), 16'h0, 8'(k)};
    dly_min = 2; dly_max = 2;
    expect_run(2, 3);
    check(exp_q.size() == 96, "model_len96", 32'(exp_q.size()), 96);
    check(exp_q[11] == 8'h01, "model_w2", 32'(exp_q[11]), 8'h01);
    check(exp_q[28] == 8'h11, "model_w7", 32'(exp_q[28]), 8'h11);
    check(exp_q[51] == 8'h03, "model_w12", 32'(exp_q[51]), 8'h03);
    check(rd_addr_q[12] == 3, "model_addr12", 32'(rd_addr_q[12]), 3);
    check(rd_bank_q[7] == 3, "model_bank7", 32'(rd_bank_q[7]), 3);
    pulse_start(7'd2, 7'd3);
    wait_done(2, 3000);

    // Zero count
    base = sent;
    pulse_start(7'd0, 7'd5);
    check(busy == 1'b1 && done == 1'b0, "zero_c1", 32'({busy, done}), 2);
    @(negedge clk);
    check(busy == 1'b0 && done == 1'b1, "zero_c2", 32'({busy, done}), 1);
    @(negedge clk);
    check(done == 1'b0, "zero_c3", 32'(done), 0);
    repeat (5) @(negedge clk);
    check(sent == base, "zero_nosend", 32'(sent), 32'(base));
    check(done_cnt == 3, "zero_done", 32'(done_cnt), 3);

    // Handshake robustness
    for (int k = 0; k < N*N; k++)
      for (int a = 0; a < 4; a++) mem[k][a] = $urandom;
    dly_min = 1; dly_max = 50; spur_en = 1'b1;
    base = sent;
    expect_run(1, 2);
    pulse_start(7'd1, 7'd2);
    c = 0;
    while (sent < base + 9 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    pulse_start(7'd3, 7'd3);
    wait_done(4, 6000);
    check(sent == base + 32, "robust_bytes", 32'(sent - base), 32);
    check(spur_cnt > 0, "spur_seen", 32'(spur_cnt), 1);
    spur_en = 1'b0;

    // Reset mid-transfer, with a start coincident with rst
    for (int k = 0; k < N*N; k++) mem[k][0] = {8'(k), 24'h123456};
    dly_min = 3; dly_max = 3;
    base = sent;
    expect_run(1, 1);
    pulse_start(7'd1, 7'd1);
    c = 0;
    while (sent < base + 5 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check(sent == base + 5, "rst_reach5", 32'(sent - base), 5);
    rst = 1'b1;
    start = 1'b1;
    a_seg_cnt = 7'd1; w_seg_cnt = 7'd1;
    exp_q.delete(); rd_addr_q.delete(); rd_bank_q.delete();
    @(posedge clk);
    #2;
    check_idle_outputs("rst_outputs");
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check(busy == 1'b0, "rst_start_ign", 32'(busy), 0);
    repeat (40) @(negedge clk);
    check(done_cnt == 4, "rst_nodone", 32'(done_cnt), 4);
    check(sent == base + 5, "rst_nosend", 32'(sent - base), 5);
    base = sent;
    expect_run(1, 1);
    pulse_start(7'd1, 7'd1);
    wait_done(5, 2000);
    check(sent == base + 16, "restart_bytes", 32'(sent - base), 16);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/result_uart_sender.md
Name: result_uart_sender

Overview:
- Return path of the matrix engine: after the systolic array finishes, streams the N x N bank of result RAMs back to the host over the UART transmitter.
- Each 32-bit float is sent as 4 bytes, one UART byte at a time, using the send_data / tx_done handshake.
- Runs between calc_done and the response-done indication; it owns the result-RAM address and read enables while busy.

Parameters:
- N, 2, systolic array dimension; there are N*N result RAMs.
- ADDR_W, 8, result RAM address width.
- DATA_W, 32, result word width; must be 32 (4 bytes per word).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse (calc_done); begins a transfer when idle
- a_seg_cnt  in  7  A-row segment count; sampled on start
- w_seg_cnt  in  7  W-column segment count; sampled on start
- ram_c_addr  out  ADDR_W  address shared by all result RAMs
- ram_c_rden  out  N*N  per-bank read enable; bit i*N+j selects bank (i,j)
- ram_c_data  in  N*N*DATA_W  bank outputs; slice [(i*N+j)*32 +: 32] is bank (i,j)
- uart_tx_data  out  8  byte to transmit
- uart_send_data  out  1  one-cycle request to the UART TX
- uart_tx_done  in  1  one-cycle pulse when the UART finishes a byte
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the transfer completes

Behaviour:
- Reset values:
  - All outputs are 0 (addr, rden, tx_data, send_data, busy, done).
  - All counters are 0; the state is IDLE.
- Data layout:
  - Bank (i,j) at address a*w_seg_cnt + w holds C[a*N+i][w*N+j].
  - Output order is C row-major: outer a, then i, then w, then j.
  - Each word is sent MSB byte first (bits 31:24 first).
  - Total bytes sent = 4 * N*N * a_seg_cnt * w_seg_cnt.
- Address arithmetic: a*w_seg_cnt + w is computed at ADDR_W bits and truncated; the caller guarantees the product fits.
- State machine (IDLE, RD_REQ, RD_WAIT, LOAD, SEND, WAIT_TX, ADV, FIN):
  - IDLE: on start, latch the segment counts and set busy.
    - If either count is 0, go to FIN.
    - Otherwise clear the counters and go to RD_REQ.
  - RD_REQ: drive ram_c_addr and assert the single rden bit for bank (i,j). Go to RD_WAIT.
  - RD_WAIT: hold addr and rden. At the end of this cycle, latch ram_c_data slice (i,j) into a 32-bit shift register. Go to LOAD.
    - Read latency is therefore 2 cycles from RD_REQ to the latched word.
  - LOAD: deassert rden, set byte_idx = 0. Go to SEND.
  - SEND: drive uart_tx_data = word[31:24] and pulse uart_send_data for exactly 1 cycle. Go to WAIT_TX.
  - WAIT_TX: hold uart_tx_data stable until uart_tx_done.
    - On tx_done, shift the word left by 8 and increment byte_idx.
    - If byte_idx was 3, go to ADV; otherwise go to SEND.
  - ADV: increment the nested counters (j, then w, then i, then a; each wraps to 0 and carries).
    - If all counters were at their maximum, go to FIN; otherwise go to RD_REQ.
  - FIN: pulse done for 1 cycle, clear busy, go to IDLE.
- Minimum byte spacing is 2 cycles after tx_done (SEND, then the next send_data). There is no back-to-back send_data.
- Boundary conditions:
  - start while busy is ignored; no counters change.
  - tx_done outside WAIT_TX is ignored.
  - tx_done coincident with send_data is not counted; only WAIT_TX accepts it.
  - rst mid-transfer clears everything to reset values within 1 cycle. No further send_data is issued, and done is not pulsed.
  - A start in the same cycle as rst is ignored.
  - Changes on a_seg_cnt/w_seg_cnt after start have no effect.
  - At most one rden bit is high at any time, and none outside RD_REQ/RD_WAIT.

Test Plan:
- 2x2 result matrix:
  - Stimulus: a_seg_cnt=1, w_seg_cnt=1, banks 00=0x3F800000, 01=0x40000000, 10=0x40400000, 11=0x40800000; tx_done returned 10 cycles after each send_data.
  - Required: 16 bytes 3F 80 00 00 40 00 00 00 40 40 00 00 40 80 00 00, then one done pulse; all reads at address 0.
- Row-major ordering:
  - Stimulus: a_seg_cnt=2, w_seg_cnt=3, bank (i,j) at address k holds 0x000000k with (i<<4|j) in bits 31:24.
  - Required: 24 words and 96 bytes. The address sequence per row is 0,0,1,1,2,2 for rows 0-1 and 3,3,4,4,5,5 for rows 2-3; the j index alternates 0/1.
- Zero count:
  - Stimulus: a_seg_cnt=0, w_seg_cnt=5, then start.
  - Required: busy high for 1 cycle, done pulse 2 cycles after start, no send_data, no rden.
- Handshake robustness:
  - Stimulus: random tx_done delay of 1-50 cycles, a spurious tx_done during RD_WAIT, and a second start pulse mid-transfer.
  - Required: byte stream identical to the reference order; exactly one done; tx_data stable throughout each WAIT_TX.
- Reset mid-transfer:
  - Stimulus: assert rst after byte 5 of the 2x2 case, then restart.
  - Required: all outputs 0 the next cycle, no done, and the fresh transfer emits all 16 bytes from byte 0.
- Read timing:
  - Check: rden is high for exactly 2 cycles per word; the data latched is the bank value present in the RD_WAIT cycle. Corrupt ram_c_data in other cycles and verify it is never transmitted.
